// File: rtl/decryption_rx_if.sv
// Ciphertext-in / plaintext-out bundle for decryption_rx.
// DECRYPTION_RX_DROP_CNT_EN adds the drop_cnt observation signal.
interface decryption_rx_if #(
   parameter int N = 8
);
   logic [N-1:0] din;
   logic         din_v;
   logic         sync;
   logic [N-1:0] dout;
   logic         dout_v;
   logic         dout_ready;
   logic         err;
`ifdef DECRYPTION_RX_DROP_CNT_EN
   logic [7:0]   drop_cnt;

   modport master (output din, din_v, sync, dout_ready,
                   input  dout, dout_v, err, drop_cnt);
   modport slave  (input  din, din_v, sync, dout_ready,
                   output dout, dout_v, err, drop_cnt);
`else
   modport master (output din, din_v, sync, dout_ready,
                   input  dout, dout_v, err);
   modport slave  (input  din, din_v, sync, dout_ready,
                   output dout, dout_v, err);
`endif
endinterface

// File: rtl/decryption_rx.sv
// Rotating-key XOR + bit-permutation decryptor with a show-ahead output FIFO.
// Optional macro DECRYPTION_RX_DROP_CNT_EN adds a saturating dropped-word counter.
module decryption_rx #(
   parameter int         N          = 8,
   parameter logic [7:0] K1         = 8'h3E,
   parameter logic [7:0] K2         = 8'h49,
   parameter logic [7:0] K3         = 8'h7E,
   parameter int         FIFO_DEPTH = 4
) (
   input logic           clock,
   input logic           rst,
   decryption_rx_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [0:0] ST_RUN = 1'b0;
   localparam logic [0:0] ST_ERR = 1'b1;

   logic [0:0]   r_state;
   logic [1:0]   r_keyIdx;
   logic [N-1:0] r_stage;
   logic         r_stageV;
   logic [AW:0]  r_wrPtr;
   logic [AW:0]  r_rdPtr;
   logic [N-1:0] r_mem [FIFO_DEPTH];

   logic [N-1:0] w_key;
   logic [N-1:0] w_x;
   logic [N-1:0] w_plain;
   logic         w_accept;
   logic         w_full;
   logic         w_empty;
   logic         w_pop;
   logic         w_push;
   logic         w_overflow;

   always_comb begin
      w_key = K1;
      case (r_keyIdx)
         2'd1:    w_key = K2;
         2'd2:    w_key = K3;
         default: w_key = K1;
      endcase
   end

   // Undo the upstream permutation after stripping the key.
   assign w_x     = bus.din ^ w_key;
   assign w_plain = {w_x[3], w_x[4], w_x[6], w_x[2], w_x[1], w_x[5], w_x[0], w_x[7]};

   assign w_accept   = bus.din_v && (r_state == ST_RUN) && !bus.sync;
   assign w_empty    = (r_wrPtr == r_rdPtr);
   assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_pop      = !w_empty && bus.dout_ready;
   assign w_push     = r_stageV && (!w_full || w_pop);
   assign w_overflow = r_stageV && w_full && !w_pop && (r_state == ST_RUN);

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_RUN;
         r_keyIdx <= 2'd0;
         r_stage  <= '0;
         r_stageV <= 1'b0;
         r_wrPtr  <= '0;
         r_rdPtr  <= '0;
      end else if (bus.sync) begin
         r_state  <= ST_RUN;
         r_keyIdx <= 2'd0;
         r_stageV <= 1'b0;
         r_wrPtr  <= '0;
         r_rdPtr  <= '0;
      end else begin
         r_stageV <= w_accept;
         if (w_accept) begin
            r_stage  <= w_plain;
            r_keyIdx <= (r_keyIdx == 2'd2) ? 2'd0 : r_keyIdx + 2'd1;
         end
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_overflow) begin
            r_state <= ST_ERR;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_push && !bus.sync) begin
         r_mem[r_wrPtr[AW-1:0]] <= r_stage;
      end
   end

   // Gate the head with empty so dout reads zero in reset and after a flush.
   assign bus.dout   = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
   assign bus.dout_v = !w_empty;
   assign bus.err    = (r_state == ST_ERR);

`ifdef DECRYPTION_RX_DROP_CNT_EN
   logic [7:0] r_dropCnt;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         r_dropCnt <= 8'd0;
      end else if (bus.sync) begin
         r_dropCnt <= 8'd0;
      end else if ((w_overflow || (bus.din_v && r_state == ST_ERR)) && r_dropCnt != 8'hFF) begin
         r_dropCnt <= r_dropCnt + 8'd1;
      end
   end

   assign bus.drop_cnt = r_dropCnt;
`endif

endmodule
